// File: rtl/cga_sram_arbiter.sv
// cga_sram_arbiter
//   Shares the single 8-bit video SRAM between CRTC character/attribute
//   fetches (strict priority) and ISA CPU memory cycles (fill the gaps).
//   All RAM pins are registered; arbitration happens in IDLE and in the
//   last cycle of every access so accesses can run back-to-back.
//
// Ports
//   clk, reset_l            pixel clock, asynchronous active-low reset
//   vid_req/vid_addr        one-cycle fetch request + character address
//   vid_char/vid_attr       fetched bytes, updated with vid_valid
//   vid_valid               one-cycle completion pulse for a fetch
//   vid_overrun             sticky: request arrived while one was pending/active
//   cpu_req/we/addr/wdata   level CPU request, held until cpu_ack
//   cpu_rdata/cpu_ack       read data and one-cycle completion pulse
//   bus_rdy                 ISA ready, low while a CPU request is outstanding
//   ram_a/ram_dout/ram_oe   SRAM address, write data, data-pin drive enable
//   ram_din/ram_we_l        SRAM read data, active-low write strobe
module cga_sram_arbiter #(
    parameter int ADDR_WIDTH  = 19,
    parameter int ATTR_OFFSET = 1
) (
    input  logic                  clk,
    input  logic                  reset_l,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic [7:0]            vid_char,
    output logic [7:0]            vid_attr,
    output logic                  vid_valid,
    output logic                  vid_overrun,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [7:0]            cpu_wdata,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_ack,
    output logic                  bus_rdy,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [7:0]            ram_dout,
    output logic                  ram_oe,
    input  logic [7:0]            ram_din,
    output logic                  ram_we_l
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_V0   = 4'd1;
    localparam logic [3:0] S_V1   = 4'd2;
    localparam logic [3:0] S_V2   = 4'd3;
    localparam logic [3:0] S_V3   = 4'd4;
    localparam logic [3:0] S_C0   = 4'd5;
    localparam logic [3:0] S_C1   = 4'd6;
    localparam logic [3:0] S_W0   = 4'd7;
    localparam logic [3:0] S_W1   = 4'd8;
    localparam logic [3:0] S_W2   = 4'd9;

    logic [3:0]            state;
    logic [3:0]            next_state;
    logic                  vid_pending;
    logic [ADDR_WIDTH-1:0] vaddr;
    logic                  served;

    logic                  in_vid;
    logic                  cpu_done;
    logic                  vid_accept;
    logic                  pend_nxt;
    logic [ADDR_WIDTH-1:0] vaddr_nxt;
    logic                  cpu_pend;
    logic [ADDR_WIDTH-1:0] attr_addr;

    always_comb begin
        in_vid     = (state == S_V0) || (state == S_V1) ||
                     (state == S_V2) || (state == S_V3);
        cpu_done   = (state == S_C1) || (state == S_W2);
        // A request during an active fetch is only flagged as overrun; the
        // captured address is still in use for the attribute address.
        vid_accept = vid_req && !in_vid;
        pend_nxt   = vid_pending || vid_accept;
        vaddr_nxt  = vid_accept ? vid_addr : vaddr;
        // The access finishing this cycle counts as served already, so a
        // held request is not selected again at its own last cycle.
        cpu_pend   = cpu_req && !served && !cpu_done;
        attr_addr  = ADDR_WIDTH'(vaddr + ADDR_WIDTH'(ATTR_OFFSET));
    end

    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE, S_V3, S_C1, S_W2: begin
                if (pend_nxt)
                    next_state = S_V0;
                else if (cpu_pend)
                    next_state = cpu_we ? S_W0 : S_C0;
                else
                    next_state = S_IDLE;
            end
            S_V0:    next_state = S_V1;
            S_V1:    next_state = S_V2;
            S_V2:    next_state = S_V3;
            S_C0:    next_state = S_C1;
            S_W0:    next_state = S_W1;
            S_W1:    next_state = S_W2;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state       <= S_IDLE;
            vid_pending <= 1'b0;
            vaddr       <= '0;
            served      <= 1'b0;
            vid_overrun <= 1'b0;
            vid_valid   <= 1'b0;
            vid_char    <= '0;
            vid_attr    <= '0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
            ram_a       <= '0;
            ram_dout    <= '0;
            ram_oe      <= 1'b0;
            ram_we_l    <= 1'b1;
        end else begin
            state       <= next_state;
            vid_pending <= (next_state == S_V0) ? 1'b0 : pend_nxt;
            vaddr       <= vaddr_nxt;
            served      <= cpu_req && (served || cpu_done);
            if (vid_req && (vid_pending || in_vid))
                vid_overrun <= 1'b1;

            vid_valid <= (state == S_V3);
            cpu_ack   <= cpu_done;
            if (state == S_V1) vid_char  <= ram_din;
            if (state == S_V3) vid_attr  <= ram_din;
            if (state == S_C1) cpu_rdata <= ram_din;

            // RAM pins are loaded on entry to the state that uses them.
            case (next_state)
                S_V0:       ram_a <= vaddr_nxt;
                S_V2:       ram_a <= attr_addr;
                S_C0, S_W0: ram_a <= cpu_addr;
                default:    ram_a <= ram_a;
            endcase
            if (next_state == S_W0)
                ram_dout <= cpu_wdata;
            ram_oe   <= (next_state == S_W0) || (next_state == S_W1) ||
                        (next_state == S_W2);
            ram_we_l <= (next_state != S_W1);
        end
    end

    // Reset term keeps the ISA bus released while the block is held in reset.
    assign bus_rdy = !reset_l || !cpu_req || served || cpu_ack;

endmodule

// File: tb/tb_cga_sram_arbiter.sv
// tb_cga_sram_arbiter
//   Scoreboard bench: stimulus pushes expected video/CPU completions into
//   queues, a negedge monitor pops and compares on vid_valid / cpu_ack.
//   An SRAM model behind the RAM pins provides read data and takes writes.
module tb_cga_sram_arbiter;

    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          reset_l = 1'b1;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [7:0]    vid_char, vid_attr;
    logic          vid_valid, vid_overrun;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_wdata = '0;
    logic [7:0]    cpu_rdata;
    logic          cpu_ack, bus_rdy;
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_dout;
    logic          ram_oe;
    logic [7:0]    ram_din;
    logic          ram_we_l;

    cga_sram_arbiter #(.ADDR_WIDTH(AW), .ATTR_OFFSET(1)) dut (
        .clk(clk), .reset_l(reset_l),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_char(vid_char), .vid_attr(vid_attr),
        .vid_valid(vid_valid), .vid_overrun(vid_overrun),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .bus_rdy(bus_rdy),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_oe(ram_oe),
        .ram_din(ram_din), .ram_we_l(ram_we_l)
    );

    always #5 clk = ~clk;

    // SRAM model: asynchronous read, write taken while the strobe is low.
    logic [7:0] mem [0:(1<<AW)-1];
    assign ram_din = mem[ram_a];
    always @(posedge clk)
        if (ram_we_l === 1'b0) mem[ram_a] <= ram_dout;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct { logic [7:0] ch; logic [7:0] at; int when; } vexp_t;
    typedef struct { logic rd; logic [7:0] data; int when; } cexp_t;
    vexp_t vq[$];
    cexp_t cq[$];

    int we_low = 0;
    int oe_high = 0;

    // Monitor
    always @(negedge clk) begin
        if (ram_we_l === 1'b0) we_low++;
        if (ram_oe === 1'b1) oe_high++;
        if (vid_valid === 1'b1) begin
            if (vq.size() == 0) chk("vid_unexpected", 32'd1, 32'd0);
            else begin
                vexp_t e;
                e = vq.pop_front();
                chk("vid_char", 32'(vid_char), 32'(e.ch));
                chk("vid_attr", 32'(vid_attr), 32'(e.at));
                chk("vid_cycle", 32'(cyc), 32'(e.when));
            end
        end
        if (cpu_ack === 1'b1) begin
            if (cq.size() == 0) chk("cpu_unexpected_ack", 32'd1, 32'd0);
            else begin
                cexp_t e;
                e = cq.pop_front();
                if (e.rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
                chk("cpu_ack_cycle", 32'(cyc), 32'(e.when));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue_vid(input logic [AW-1:0] a, input logic [7:0] ch, input logic [7:0] at);
        vid_req  = 1'b1;
        vid_addr = a;
        vq.push_back('{ch: ch, at: at, when: cyc + 5});
    endtask

    task automatic issue_cpu(input logic we, input logic [AW-1:0] a, input logic [7:0] wd,
                             input logic [7:0] rd, input int lat);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        cq.push_back('{rd: !we, data: rd, when: cyc + lat});
    endtask

    // Waits at negedges for cpu_ack; a missing ack is a failed comparison.
    task automatic wait_ack(input string nm, output int lows);
        int n;
        logic got;
        got  = 1'b0;
        lows = 0;
        n    = 0;
        while (!got && n < 30) begin
            @(negedge clk);
            if (cpu_ack === 1'b1) got = 1'b1;
            else if (bus_rdy === 1'b0) lows++;
            n++;
        end
        chk(nm, 32'(got), 32'd1);
    endtask

    initial begin
        int lows;
        int acks;
        mem[19'h00100] = 8'h41;
        mem[19'h00101] = 8'h1F;
        mem[19'h7FFFF] = 8'h33;
        mem[19'h00000] = 8'h5C;

        // Reset state
        #3 reset_l = 1'b0;
        step(3);
        chk("rst_ram_we_l", 32'(ram_we_l), 32'd1);
        chk("rst_ram_oe", 32'(ram_oe), 32'd0);
        chk("rst_ram_a", 32'(ram_a), 32'd0);
        chk("rst_ram_dout", 32'(ram_dout), 32'd0);
        chk("rst_bus_rdy", 32'(bus_rdy), 32'd1);
        chk("rst_flags", {28'd0, vid_valid, cpu_ack, vid_overrun, 1'b0}, 32'd0);
        chk("rst_data", {8'd0, vid_char, vid_attr, cpu_rdata}, 32'd0);
        reset_l = 1'b1;
        step(2);

        // Video fetch from 0x100
        we_low = 0;
        issue_vid(19'h00100, 8'h41, 8'h1F);
        step(1);
        vid_req = 1'b0;
        step(8);
        chk("vid_we_l_quiet", 32'(we_low), 32'd0);

        // CPU write 0xA5 to 0x7FFFF
        we_low = 0;
        oe_high = 0;
        issue_cpu(1'b1, 19'h7FFFF, 8'hA5, 8'h00, 4);
        @(negedge clk);
        chk("wr_bus_rdy_low", 32'(bus_rdy), 32'd0);
        wait_ack("wr_ack_seen", lows);
        chk("wr_we_low_cycles", 32'(we_low), 32'd1);
        chk("wr_oe_high_cycles", 32'(oe_high), 32'd3);
        step(1);
        cpu_req = 1'b0;
        chk("wr_mem", 32'(mem[19'h7FFFF]), 32'hA5);
        step(2);

        // CPU read of 0x7FFFF
        issue_cpu(1'b0, 19'h7FFFF, 8'h00, 8'hA5, 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rd_bus_rdy", 32'(bus_rdy), (i < 3) ? 32'd0 : 32'd1);
        end
        step(1);
        cpu_req = 1'b0;
        step(2);

        // Attribute address wraps past the top of RAM
        issue_vid(19'h7FFFF, 8'hA5, 8'h5C);
        step(1);
        vid_req = 1'b0;
        step(8);

        // Simultaneous video and CPU read: video first, CPU right after V3
        issue_vid(19'h00100, 8'h41, 8'h1F);
        issue_cpu(1'b0, 19'h00100, 8'h00, 8'h41, 7);
        step(1);
        vid_req = 1'b0;
        #1;
        wait_ack("sim_ack_seen", lows);
        chk("sim_bus_rdy_low_cycles", 32'(lows + 1), 32'd7);
        step(1);
        cpu_req = 1'b0;
        step(3);

        // Overrun: second request two cycles into the first
        chk("ovr_before", 32'(vid_overrun), 32'd0);
        issue_vid(19'h00100, 8'h41, 8'h1F);
        step(1);
        vid_req = 1'b0;
        step(1);
        vid_req = 1'b1;
        step(1);
        vid_req = 1'b0;
        chk("ovr_set", 32'(vid_overrun), 32'd1);
        step(6);

        // Held CPU request is served exactly once
        issue_cpu(1'b0, 19'h00101, 8'h00, 8'h1F, 3);
        wait_ack("hold_ack_seen", lows);
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_ack === 1'b1) acks++;
        end
        chk("hold_no_second_ack", 32'(acks), 32'd0);
        chk("hold_bus_rdy", 32'(bus_rdy), 32'd1);
        step(1);
        cpu_req = 1'b0;
        step(2);
        chk("ovr_sticky", 32'(vid_overrun), 32'd1);

        // Reset in the middle of the write strobe
        issue_cpu(1'b1, 19'h00200, 8'h77, 8'h00, 4);
        void'(cq.pop_back());
        step(2);
        chk("w1_strobe_low", 32'(ram_we_l), 32'd0);
        #2 reset_l = 1'b0;
        #1;
        chk("rst_w1_we_l", 32'(ram_we_l), 32'd1);
        chk("rst_w1_oe", 32'(ram_oe), 32'd0);
        chk("rst_w1_bus_rdy", 32'(bus_rdy), 32'd1);
        chk("rst_w1_overrun", 32'(vid_overrun), 32'd0);
        cpu_req = 1'b0;
        step(2);
        reset_l = 1'b1;
        step(3);

        chk("vid_queue_drained", 32'(vq.size()), 32'd0);
        chk("cpu_queue_drained", 32'(cq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
